timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped 32-bit down-counting timer. It is the peripheral that consumes the store stage's byte enables and write data on the system bus.
- Occupies a 12-byte window of three word registers: CTRL at +0x0, PRESET at +0x4, COUNT at +0x8 (COUNT is read-only).
- Raises an interrupt request to the CP0 interrupt input when the count expires.
- Supports one-shot mode and auto-reload mode.

Parameters:
- BASE, 32'h0000_7F00, byte address of CTRL; the window is BASE..BASE+0xB.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  bus byte address (word registers use addr[3:2]).
- we  in  1  bus write strobe.
- byteen  in  4  byte enables from the store stage.
- wdata  in  32  store data.
- rdata  out  32  read data; combinational from addr.
- irq  out  1  interrupt request.

Behaviour:
- Reset (reset low, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq flag=0. Consequently irq=0 and rdata follows addr with zeroed registers.
- CTRL fields:
  - bit0 EN.
  - bits[2:1] MODE: 00 one-shot, 01 auto-reload; 1x behaves as 00.
  - bit3 IM, interrupt mask (1 = enabled).
  - bits[31:4] read as 0, writes ignored.
- Write acceptance:
  - A write is accepted only when we=1, addr lies in BASE..BASE+0xB, and byteen=4'b1111.
  - Partial-byteen writes are ignored entirely.
  - A write to offset 0x8 (COUNT) is ignored.
- Read: rdata = CTRL, PRESET or COUNT by addr[3:2]; 0 for offset 0xC or out of window.
- State machine, evaluated each edge:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE and hold COUNT.
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else (COUNT is 0 or 1), COUNT<=0, go to INT, set irq flag.
  - INT:
    - MODE=00: EN<=0, go to IDLE.
    - MODE=01: go to IDLE (EN remains set, so the counter reloads).
- irq = IM & irq flag.
  - MODE=00: the flag is sticky; it is cleared only by an accepted write to CTRL or PRESET.
  - MODE=01: the flag is set only while state=INT, giving a one-cycle pulse.
- Timing for one-shot operation:
  - Accepted CTRL write at edge E0 with EN=1.
  - irq rises after edge E0+max(PRESET,1)+2.
  - Example: PRESET=3 gives irq after E5.
- Auto-reload period: INT-to-INT spacing is max(PRESET,1)+3 cycles.
- Simultaneous events:
  - A CPU write to CTRL on the same edge the FSM clears EN (INT, MODE=00): the CPU value wins.
  - A write that clears the flag on the same edge as an expiry: the expiry wins and the flag is set.
  - A PRESET write during CNT does not affect the running COUNT; it takes effect at the next LOAD.
- Wrap-around: COUNT never decrements below 0. PRESET=0 behaves as PRESET=1.
- Reset low mid-count: immediate return to the reset state, with no clock needed.

Decomposition:
- Shared package tc_pkg holds:
  - state encoding IDLE/LOAD/CNT/INT (2 bits);
  - register offsets 2'd0/2'd1/2'd2;
  - MODE constants;
  - CTRL bit positions.
- No sub-module: the register file, FSM and decrementer all live in timer_counter.

Test Plan:
- Reset and partial writes:
  - Assert reset low mid-run -> all reads return 0 and irq=0 immediately.
  - Then write 0xFFFF_FFFF to CTRL with byteen=4'b0011 -> CTRL still reads 0.
- One-shot:
  - Write PRESET=3, then CTRL=0x9 (EN, IM, MODE=00) at E0 -> COUNT reads 3, 2, 1 over E2..E4.
  - irq=1 after E5 and stays 1.
  - CTRL reads 0x8.
  - A write of PRESET=5 drops irq on the next edge.
- Auto-reload: PRESET=2, CTRL=0xB -> irq is a one-cycle pulse every 5 cycles, repeating for at least 4 periods.
- Disable mid-count: PRESET=100, start the timer, then write CTRL=0x8 when COUNT=50 -> state returns to IDLE, COUNT holds 50, no irq.
- Expiry collision: write CTRL=0x9 on the same edge as a one-shot INT->IDLE transition -> CTRL reads 0x9, the timer restarts and the irq flag stays set.
- Masking and read-only COUNT:
  - Run a one-shot with IM=0 -> irq stays 0; COUNT reads 0 after expiry.
  - A write of 0x1234 to BASE+0x8 leaves COUNT unchanged.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared constants for the memory-mapped down-counting timer.
// State encoding, register word offsets, MODE values and CTRL bit positions.
package tc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  localparam logic [31:0] WIN_BYTES = 32'd12;

endpackage

// File: rtl/timer_counter.sv
// Bus-mapped 32-bit down-counter (CTRL/PRESET/COUNT) with one-shot and auto-reload irq.
// Register writes take effect on the next edge; rdata is combinational from addr.
module timer_counter
  import tc_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic              flag_q, flag_d;

  logic [31:0] off;
  logic        in_win;
  logic [1:0]  idx;
  logic        wr_acc, wr_ctrl, wr_preset;
  logic        en, auto_mode;

  assign off       = addr - BASE;
  assign in_win    = (off < WIN_BYTES);
  assign idx       = off[3:2];
  assign wr_acc    = we && in_win && (byteen == 4'b1111);
  assign wr_ctrl   = wr_acc && (idx == OFF_CTRL);
  assign wr_preset = wr_acc && (idx == OFF_PRESET);

  assign en        = ctrl_q[CTRL_EN];
  assign auto_mode = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (!auto_mode) ctrl_d[CTRL_EN] = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // CPU write overrides the FSM's own EN clear on the same edge.
    if (wr_ctrl)   ctrl_d   = wdata[CTRL_W-1:0];
    if (wr_preset) preset_d = wdata;
  end

  // One-shot flag: the INT cycle counts as part of the expiry, so a clearing
  // write landing on entry to or exit from INT loses to it.
  always_comb begin
    flag_d = flag_q;
    if (auto_mode) begin
      flag_d = (state_d == ST_INT);
    end else if ((state_d == ST_INT) || (state_q == ST_INT)) begin
      flag_d = 1'b1;
    end else if (wr_ctrl || wr_preset) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      flag_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      state_q  <= state_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (in_win) begin
      case (idx)
        OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
        OFF_PRESET: rdata = preset_q;
        OFF_COUNT:  rdata = count_q;
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign irq = ctrl_q[CTRL_IM] && flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: vector table plus hand-written multi-cycle sequences.
module tb_timer_counter;

  localparam logic [31:0] B  = 32'h0000_7F00;
  localparam logic [31:0] AC = B;
  localparam logic [31:0] AP = B + 32'h4;
  localparam logic [31:0] AN = B + 32'h8;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_counter #(.BASE(B)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] ra;
    logic [31:0] er;
    logic        ei;
  } vec_t;

  vec_t tbl[29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, clock, then point addr at ra for sampling.
  task automatic step(input logic w, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic [31:0] ra);
    @(negedge clk);
    we = w; addr = a; byteen = be; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; byteen = 4'h0; addr = ra;
    #1;
  endtask

  task automatic idle(input logic [31:0] ra);
    step(1'b0, ra, 4'h0, 32'h0, ra);
  endtask

  initial begin
    bit found;
    logic exp_irq;

    reset = 1'b1; we = 1'b0; addr = AC; byteen = 4'h0; wdata = 32'h0;
    #2 reset = 1'b0;
    #1;
    chk("reset_ctrl", rdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the middle of a count.
    step(1'b1, AP, 4'hF, 32'd10, AP);
    step(1'b1, AC, 4'hF, 32'h9, AN);
    idle(AN); idle(AN); idle(AN);
    idle(AN);
    chk("midrun_count", rdata, 32'd8);
    #2 reset = 1'b0;
    #1 chk("areset_count", rdata, 32'h0);
    addr = AC;
    #1 chk("areset_ctrl", rdata, 32'h0);
    addr = AP;
    #1 chk("areset_preset", rdata, 32'h0);
    chk("areset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    tbl[0]  = '{1'b1, AC, 4'h3, 32'hFFFF_FFFF, AC, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, AC, 4'hF, 32'hFFFF_FFFF, AC, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, AP, 4'hF, 32'd3,         AP, 32'd3, 1'b0};
    tbl[3]  = '{1'b1, AC, 4'hF, 32'h9,         AC, 32'h9, 1'b0};
    tbl[4]  = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd0, 1'b0};
    tbl[5]  = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd3, 1'b0};
    tbl[6]  = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd2, 1'b0};
    tbl[7]  = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd1, 1'b0};
    tbl[8]  = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd0, 1'b1};
    tbl[9]  = '{1'b0, AC, 4'h0, 32'h0,         AC, 32'h8, 1'b1};
    tbl[10] = '{1'b0, AC, 4'h0, 32'h0,         AC, 32'h8, 1'b1};
    tbl[11] = '{1'b1, AP, 4'hF, 32'd5,         AP, 32'd5, 1'b0};
    tbl[12] = '{1'b1, B + 32'hC, 4'hF, 32'hDEAD, B + 32'hC, 32'h0, 1'b0};
    tbl[13] = '{1'b1, B - 32'h4, 4'hF, 32'h1,  AC, 32'h8, 1'b0};
    tbl[14] = '{1'b1, AP, 4'hC, 32'd7,         AP, 32'd5, 1'b0};
    tbl[15] = '{1'b1, AP, 4'hF, 32'd1,         AP, 32'd1, 1'b0};
    tbl[16] = '{1'b1, AC, 4'hF, 32'h1,         AC, 32'h1, 1'b0};
    tbl[17] = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd0, 1'b0};
    tbl[18] = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd1, 1'b0};
    tbl[19] = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd0, 1'b0};
    tbl[20] = '{1'b0, AC, 4'h0, 32'h0,         AC, 32'h0, 1'b0};
    tbl[21] = '{1'b1, AC, 4'hF, 32'h8,         AC, 32'h8, 1'b0};
    tbl[22] = '{1'b1, AP, 4'hF, 32'd0,         AP, 32'd0, 1'b0};
    tbl[23] = '{1'b1, AC, 4'hF, 32'h9,         AC, 32'h9, 1'b0};
    tbl[24] = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd0, 1'b0};
    tbl[25] = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd0, 1'b0};
    tbl[26] = '{1'b0, AN, 4'h0, 32'h0,         AN, 32'd0, 1'b1};
    tbl[27] = '{1'b0, AC, 4'h0, 32'h0,         AC, 32'h8, 1'b1};
    tbl[28] = '{1'b1, AC, 4'hF, 32'hFFFF_FFF8, AC, 32'h8, 1'b0};

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].d, tbl[i].ra);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].er);
      chk($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].ei});
    end

    // Auto-reload with PRESET=2: one-cycle pulse every 5 edges, first at E0+4.
    step(1'b1, AP, 4'hF, 32'd2, AP);
    step(1'b1, AC, 4'hF, 32'hB, AN);
    for (int k = 1; k <= 25; k++) begin
      idle(AN);
      exp_irq = (k >= 4) && (((k - 4) % 5) == 0);
      chk($sformatf("auto_k%0d_irq", k), {31'b0, irq}, {31'b0, exp_irq});
    end
    step(1'b1, AC, 4'hF, 32'h0, AC);

    // Disable mid-count: stopping write lands on the edge that produces 50.
    step(1'b1, AP, 4'hF, 32'd100, AP);
    step(1'b1, AC, 4'hF, 32'h9, AN);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      idle(AN);
      if (rdata == 32'd51) found = 1'b1;
    end
    chk("dis_reach51", {31'b0, found}, 32'h1);
    step(1'b1, AC, 4'hF, 32'h8, AN);
    chk("dis_count_at_write", rdata, 32'd50);
    idle(AN); idle(AN); idle(AN);
    chk("dis_count_hold", rdata, 32'd50);
    chk("dis_irq", {31'b0, irq}, 32'h0);
    step(1'b1, AN, 4'hF, 32'h1234, AN);
    chk("count_readonly", rdata, 32'd50);
    addr = AC;
    #1 chk("dis_ctrl", rdata, 32'h8);

    // Expiry collision: CPU re-enables on the INT->IDLE edge.
    step(1'b1, AP, 4'hF, 32'd3, AP);
    step(1'b1, AC, 4'hF, 32'h9, AN);
    for (int k = 1; k <= 5; k++) idle(AN);
    chk("col_int_irq", {31'b0, irq}, 32'h1);
    chk("col_int_count", rdata, 32'd0);
    step(1'b1, AC, 4'hF, 32'h9, AC);
    chk("col_ctrl", rdata, 32'h9);
    chk("col_irq_kept", {31'b0, irq}, 32'h1);
    idle(AN);
    idle(AN);
    chk("col_restart_count", rdata, 32'd3);
    chk("col_irq_sticky", {31'b0, irq}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
